// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB and issue signals between the rename stage, the ALU
// reservation station and the execute stage.
interface alu_rs_if #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned TAG_W    = 4
);
  logic                disp_valid;
  logic                disp_ready;
  logic [4:0]          disp_alu_func;
  logic                disp_opsel1;
  logic                disp_opsel2;
  logic                disp_rs1_rdy;
  logic [TAG_W-1:0]    disp_rs1_tag;
  logic [WORD-1:0]     disp_rs1_value;
  logic                disp_rs2_rdy;
  logic [TAG_W-1:0]    disp_rs2_tag;
  logic [WORD-1:0]     disp_rs2_value;
  logic [WORD-1:0]     disp_imm;
  logic [ADDR_LEN-1:0] disp_pc;
  logic [TAG_W-1:0]    disp_dst_tag;

  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [WORD-1:0]     cdb_value;

  logic                iss_valid;
  logic                iss_ready;
  logic [4:0]          iss_alu_func;
  logic                iss_opsel1;
  logic                iss_opsel2;
  logic [WORD-1:0]     iss_rs1_value;
  logic [WORD-1:0]     iss_rs2_value;
  logic [WORD-1:0]     iss_imm;
  logic [ADDR_LEN-1:0] iss_pc;
  logic [TAG_W-1:0]    iss_dst_tag;

  modport master (
    output disp_valid, disp_alu_func, disp_opsel1, disp_opsel2,
           disp_rs1_rdy, disp_rs1_tag, disp_rs1_value,
           disp_rs2_rdy, disp_rs2_tag, disp_rs2_value,
           disp_imm, disp_pc, disp_dst_tag,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  disp_ready, iss_valid, iss_alu_func, iss_opsel1, iss_opsel2,
           iss_rs1_value, iss_rs2_value, iss_imm, iss_pc, iss_dst_tag
  );

  modport slave (
    input  disp_valid, disp_alu_func, disp_opsel1, disp_opsel2,
           disp_rs1_rdy, disp_rs1_tag, disp_rs1_value,
           disp_rs2_rdy, disp_rs2_tag, disp_rs2_value,
           disp_imm, disp_pc, disp_dst_tag,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output disp_ready, iss_valid, iss_alu_func, iss_opsel1, iss_opsel2,
           iss_rs1_value, iss_rs2_value, iss_imm, iss_pc, iss_dst_tag
  );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: compacting issue queue for ALU ops with CDB wakeup and
// oldest-ready select. Optional macro RS_WAKEUP_BYPASS_EN gives same-cycle wakeup-to-issue.
module alu_reservation_station #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  alu_rs_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]          func;
    logic                opsel1;
    logic                opsel2;
    logic                rs1_rdy;
    logic [TAG_W-1:0]    rs1_tag;
    logic [WORD-1:0]     rs1_val;
    logic                rs2_rdy;
    logic [TAG_W-1:0]    rs2_tag;
    logic [WORD-1:0]     rs2_val;
    logic [WORD-1:0]     imm;
    logic [ADDR_LEN-1:0] pc;
    logic [TAG_W-1:0]    dst_tag;
  } entry_t;

  // Capture a CDB broadcast into any still-waiting operand whose producer tag matches.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [TAG_W-1:0] t, input logic [WORD-1:0] d);
    entry_t r;
    r = e;
    if (v && !e.rs1_rdy && (e.rs1_tag == t)) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = d;
    end
    if (v && !e.rs2_rdy && (e.rs2_tag == t)) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = d;
    end
    return r;
  endfunction

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  entry_t             ent_w [DEPTH+1];
  entry_t             disp_w;
  entry_t             iss_e;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   wr_idx;
  logic [DEPTH-1:0]   elig;
  logic [IDX_W-1:0]   sel;
  logic               found;
  logic               disp_fire;
  logic               iss_fire;

  assign bus.disp_ready = (count_q < CNT_W'(DEPTH));
  assign disp_fire      = bus.disp_valid & bus.disp_ready;
  assign iss_fire       = found & bus.iss_ready;
  assign wr_idx         = count_q - CNT_W'(iss_fire);

  // Post-wakeup view of every resident entry and of the op being dispatched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end
    ent_w[DEPTH] = ent_w[DEPTH-1];
    disp_w = wake('{func:    bus.disp_alu_func,
                    opsel1:  bus.disp_opsel1,
                    opsel2:  bus.disp_opsel2,
                    rs1_rdy: bus.disp_rs1_rdy,
                    rs1_tag: bus.disp_rs1_tag,
                    rs1_val: bus.disp_rs1_value,
                    rs2_rdy: bus.disp_rs2_rdy,
                    rs2_tag: bus.disp_rs2_tag,
                    rs2_val: bus.disp_rs2_value,
                    imm:     bus.disp_imm,
                    pc:      bus.disp_pc,
                    dst_tag: bus.disp_dst_tag},
                  bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  end

  // Eligibility: bypass build lets this cycle's broadcast complete an entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      elig[i] = (CNT_W'(i) < count_q) & ent_w[i].rs1_rdy & ent_w[i].rs2_rdy;
`else
      elig[i] = (CNT_W'(i) < count_q) & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
`endif
    end
  end

  // Oldest-ready select: lowest eligible slot wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && elig[i]) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef RS_WAKEUP_BYPASS_EN
    iss_e = ent_w[sel];
`else
    iss_e = ent_q[sel];
`endif
  end

  assign bus.iss_valid     = found;
  assign bus.iss_alu_func  = iss_e.func;
  assign bus.iss_opsel1    = iss_e.opsel1;
  assign bus.iss_opsel2    = iss_e.opsel2;
  assign bus.iss_rs1_value = iss_e.rs1_val;
  assign bus.iss_rs2_value = iss_e.rs2_val;
  assign bus.iss_imm       = iss_e.imm;
  assign bus.iss_pc        = iss_e.pc;
  assign bus.iss_dst_tag   = iss_e.dst_tag;

  // Next state: shift down above the issued slot, then append the dispatched op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_w[i];
      if (iss_fire && (i >= int'(sel))) begin
        ent_d[i] = ent_w[i+1];
      end
      if (disp_fire && (CNT_W'(i) == wr_idx)) begin
        ent_d[i] = disp_w;
      end
    end
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
    ent_q <= ent_d;
  end

endmodule
